// File: rtl/txt_pkg.sv
// Shared opcodes, cursor-advance modes and engine states for the text-mode command engine.
package txt_pkg;

    localparam logic [15:0] OP_NOP  = 16'h0000;
    localparam logic [15:0] OP_RST  = 16'h00C0;
    localparam logic [15:0] OP_PUT  = 16'h00C1;
    localparam logic [15:0] OP_BS   = 16'h00C2;
    localparam logic [15:0] OP_SETY = 16'h00C3;
    localparam logic [15:0] OP_SETX = 16'h00C4;
    localparam logic [15:0] OP_CLS  = 16'h00C5;
    localparam logic [15:0] OP_NL   = 16'h00C6;
    localparam logic [15:0] OP_ATTR = 16'h00C7;
    localparam logic [15:0] OP_MODE = 16'h00C8;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_SCROLL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PARAM,
        EXEC,
        CLEAR,
        SCR_RD,
        SCR_WR,
        BLANK
    } state_t;

endpackage

// File: rtl/txt_ram.sv
// Simple dual-port character RAM: port A read/write for the engine, port B read-only
// for the display. Both reads are registered and read-first.
module txt_ram #(
    parameter int WIDTH  = 12,
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic [WIDTH-1:0]  a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WIDTH-1:0]  b_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_rdata <= mem[a_addr];
    end

    // Only the output register is cleared; the array itself keeps its contents.
    always_ff @(posedge clk) begin
        if (clr) begin
            b_rdata <= '0;
        end else begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/txt_cmd_engine.sv
// Text-mode command processor: decodes opcode/parameter pairs from the CPU and maintains
// a COLS x ROWS {attr,char} buffer with cursor, clear and scroll operations.
module txt_cmd_engine
    import txt_pkg::*;
#(
    parameter int COLS   = 40,
    parameter int ROWS   = 25,
    parameter int CHAR_W = 8,
    parameter int ATTR_W = 4,
    parameter int CMD_W  = 16,
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       cmd_valid,
    input  logic [CMD_W-1:0]           cmd_word,
    output logic                       cmd_ready,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [CHAR_W+ATTR_W-1:0]   rd_data,
    output logic [$clog2(COLS)-1:0]    cur_x,
    output logic [$clog2(ROWS)-1:0]    cur_y,
    output logic                       busy
);

    localparam int X_W    = $clog2(COLS);
    localparam int Y_W    = $clog2(ROWS);
    localparam int DATA_W = CHAR_W + ATTR_W;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [ADDR_W-1:0] LAST_CELL   = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_SCROLL = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
    localparam logic [X_W-1:0]    X_MAX       = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]    Y_MAX       = Y_W'(ROWS - 1);

    generate
        if (CELLS > 2**ADDR_W) begin : g_addr_check
            $error("txt_cmd_engine: COLS*ROWS does not fit in ADDR_W bits");
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [CMD_W-1:0]    op_reg, op_next;
    logic [CMD_W-1:0]    param_reg, param_next;
    logic [X_W-1:0]      cur_x_reg, cur_x_next;
    logic [Y_W-1:0]      cur_y_reg, cur_y_next;
    logic [ATTR_W-1:0]   attr_reg, attr_next;
    logic                mode_reg, mode_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;

    logic                a_we;
    logic                ram_we;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_wdata;
    logic [DATA_W-1:0]   a_rdata;
    logic [ADDR_W-1:0]   cur_addr;

    assign cur_addr = ADDR_W'(cur_y_reg) * COLS_A + ADDR_W'(cur_x_reg);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            param_reg <= '0;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
            attr_reg  <= ATTR_W'(4'hF);
            mode_reg  <= MODE_WRAP;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            param_reg <= param_next;
            cur_x_reg <= cur_x_next;
            cur_y_reg <= cur_y_next;
            attr_reg  <= attr_next;
            mode_reg  <= mode_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        param_next = param_reg;
        cur_x_next = cur_x_reg;
        cur_y_next = cur_y_reg;
        attr_next  = attr_reg;
        mode_next  = mode_reg;
        idx_next   = idx_reg;
        a_we       = 1'b0;
        a_addr     = cur_addr;
        a_wdata    = '0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && (cmd_word != CMD_W'(OP_NOP))) begin
                    op_next    = cmd_word;
                    state_next = PARAM;
                end
            end
            PARAM: begin
                if (cmd_valid) begin
                    param_next = cmd_word;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = IDLE;
                case (op_reg)
                    CMD_W'(OP_RST): begin
                        cur_x_next = '0;
                        cur_y_next = '0;
                        attr_next  = ATTR_W'(4'hF);
                        mode_next  = MODE_WRAP;
                    end
                    CMD_W'(OP_PUT): begin
                        a_we    = 1'b1;
                        a_wdata = {attr_reg, param_reg[CHAR_W-1:0]};
                        if (cur_x_reg < X_MAX) begin
                            cur_x_next = cur_x_reg + X_W'(1);
                        end else if (cur_y_reg < Y_MAX) begin
                            cur_x_next = '0;
                            cur_y_next = cur_y_reg + Y_W'(1);
                        end else if (mode_reg == MODE_WRAP) begin
                            cur_x_next = '0;
                            cur_y_next = '0;
                        end else begin
                            idx_next   = '0;
                            state_next = SCR_RD;
                        end
                    end
                    CMD_W'(OP_BS): begin
                        // Cells are row-major, so the previous cell is always cur_addr-1.
                        if ((cur_x_reg != '0) || (cur_y_reg != '0)) begin
                            a_we   = 1'b1;
                            a_addr = cur_addr - ADDR_W'(1);
                            if (cur_x_reg != '0) begin
                                cur_x_next = cur_x_reg - X_W'(1);
                            end else begin
                                cur_x_next = X_MAX;
                                cur_y_next = cur_y_reg - Y_W'(1);
                            end
                        end
                    end
                    CMD_W'(OP_SETY): begin
                        if (param_reg > CMD_W'(ROWS - 1)) begin
                            cur_y_next = Y_MAX;
                        end else begin
                            cur_y_next = param_reg[Y_W-1:0];
                        end
                    end
                    CMD_W'(OP_SETX): begin
                        if (param_reg > CMD_W'(COLS - 1)) begin
                            cur_x_next = X_MAX;
                        end else begin
                            cur_x_next = param_reg[X_W-1:0];
                        end
                    end
                    CMD_W'(OP_CLS): begin
                        idx_next   = '0;
                        state_next = CLEAR;
                    end
                    CMD_W'(OP_NL): begin
                        cur_x_next = '0;
                        if (cur_y_reg < Y_MAX) begin
                            cur_y_next = cur_y_reg + Y_W'(1);
                        end else if (mode_reg == MODE_WRAP) begin
                            cur_y_next = '0;
                        end else begin
                            idx_next   = '0;
                            state_next = SCR_RD;
                        end
                    end
                    CMD_W'(OP_ATTR): attr_next = param_reg[ATTR_W-1:0];
                    CMD_W'(OP_MODE): mode_next = param_reg[0];
                    default: ;
                endcase
            end
            CLEAR: begin
                a_we   = 1'b1;
                a_addr = idx_reg;
                if (idx_reg == LAST_CELL) begin
                    cur_x_next = '0;
                    cur_y_next = '0;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + ADDR_W'(1);
                end
            end
            SCR_RD: begin
                a_addr     = idx_reg + COLS_A;
                state_next = SCR_WR;
            end
            SCR_WR: begin
                // a_rdata holds the cell one row below, fetched in SCR_RD.
                a_we     = 1'b1;
                a_addr   = idx_reg;
                a_wdata  = a_rdata;
                idx_next = idx_reg + ADDR_W'(1);
                if (idx_reg == LAST_SCROLL) begin
                    state_next = BLANK;
                end else begin
                    state_next = SCR_RD;
                end
            end
            BLANK: begin
                a_we   = 1'b1;
                a_addr = idx_reg;
                if (idx_reg == LAST_CELL) begin
                    cur_x_next = '0;
                    cur_y_next = Y_MAX;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A reset cycle must never disturb the buffer, even mid-operation.
    assign ram_we = a_we & ~clr;

    txt_ram #(
        .WIDTH  (DATA_W),
        .DEPTH  (CELLS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .clr     (clr),
        .a_we    (ram_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_addr  (rd_addr),
        .b_rdata (rd_data)
    );

    assign cmd_ready = (state_reg == IDLE) || (state_reg == PARAM);
    assign busy      = (state_reg == CLEAR) || (state_reg == SCR_RD) ||
                       (state_reg == SCR_WR) || (state_reg == BLANK);
    assign cur_x     = cur_x_reg;
    assign cur_y     = cur_y_reg;

endmodule

// File: tb/tb_txt_cmd_engine.sv
// Directed bench for txt_cmd_engine at default 40x25 geometry; expected values are hand-derived.
module tb_txt_cmd_engine;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_word = '0;
    logic        cmd_ready;
    logic [9:0]  rd_addr = '0;
    logic [11:0] rd_data;
    logic [5:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int last_busy;
    bit last_rdy;

    txt_cmd_engine dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_word  (cmd_word),
        .cmd_ready (cmd_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_word  = w;
        while (!cmd_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check_eq("send_ready_timeout", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Wait past EXEC and count busy cycles; also notes whether cmd_ready rose while busy.
    task automatic settle();
        @(negedge clk);
        @(negedge clk);
        last_busy = 0;
        last_rdy  = 1'b0;
        while (busy && last_busy < 5000) begin
            last_busy++;
            if (cmd_ready) last_rdy = 1'b1;
            @(negedge clk);
        end
        if (last_busy >= 5000) check_eq("busy_timeout", busy, 0);
    endtask

    task automatic cmd(input logic [15:0] op, input logic [15:0] p);
        send(op);
        send(p);
        settle();
        $display("cmd %h/%h -> cursor (%0d,%0d) busy_cycles=%0d", op, p, cur_x, cur_y, last_busy);
    endtask

    task automatic read_cell(input int a, output logic [11:0] d);
        @(negedge clk);
        rd_addr = 10'(a);
        @(posedge clk);
        #1 d = rd_data;
    endtask

    task automatic check_cell(input string tag, input int a, input logic [11:0] exp);
        logic [11:0] d;
        read_cell(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        check_eq({tag, "_x"}, cur_x, x);
        check_eq({tag, "_y"}, cur_y, y);
    endtask

    initial begin
        logic [11:0] d;
        int nz;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_cursor("rst_cur", 0, 0);
        check_eq("rst_rd_data", rd_data, 0);
        clr = 1'b0;

        // Two puts with reset attribute
        cmd(16'h00C1, 16'h0041);
        cmd(16'h00C1, 16'h0042);
        check_cell("put_cell0", 0, 12'hF41);
        check_cell("put_cell1", 1, 12'hF42);
        check_cursor("put_cur", 2, 0);
        check_eq("put_ready", cmd_ready, 1);

        // Put at last cell in WRAP mode
        cmd(16'h00C7, 16'h0003);
        cmd(16'h00C4, 16'h0027);
        cmd(16'h00C3, 16'h0018);
        check_cursor("pos_last", 39, 24);
        cmd(16'h00C1, 16'h0058);
        check_eq("wrap_busy", last_busy, 0);
        check_cell("wrap_cell999", 999, 12'h358);
        check_cursor("wrap_cur", 0, 0);

        // Clear, with read-first check on the first cell written
        send(16'h00C5);
        send(16'h0000);
        @(negedge clk);
        @(negedge clk);
        check_eq("cls_busy_start", busy, 1);
        rd_addr = 10'd0;
        @(posedge clk);
        #1 check_eq("read_first_old", rd_data, 12'hF41);
        @(negedge clk);
        @(posedge clk);
        #1 check_eq("read_after_write", rd_data, 12'h000);
        n = 2;
        @(negedge clk);
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        $display("cmd 00c5/0000 -> cursor (%0d,%0d) busy_cycles=%0d", cur_x, cur_y, n);
        check_eq("cls_busy_cycles", n, 1000);
        check_cursor("cls_cur", 0, 0);
        nz = 0;
        for (int i = 0; i < 1000; i++) begin
            read_cell(i, d);
            if (d != 12'h000) nz++;
        end
        check_eq("cls_nonzero", nz, 0);

        // Backspace: no-op at origin, normal step back, row wrap-back
        cmd(16'h00C1, 16'h0041);
        cmd(16'h00C4, 16'h0000);
        cmd(16'h00C2, 16'h0000);
        check_cursor("bs_origin_cur", 0, 0);
        check_cell("bs_origin_cell", 0, 12'h341);
        cmd(16'h00C4, 16'h0001);
        cmd(16'h00C2, 16'h0000);
        check_cursor("bs_step_cur", 0, 0);
        check_cell("bs_step_cell", 0, 12'h000);
        cmd(16'h00C3, 16'h0001);
        cmd(16'h00C2, 16'h0000);
        check_cursor("bs_row_cur", 39, 0);

        // Scroll on newline at the bottom row
        cmd(16'h00C8, 16'h0001);
        for (int r = 0; r < 25; r++) begin
            cmd(16'h00C3, 16'(r));
            cmd(16'h00C4, 16'h0000);
            cmd(16'h00C1, 16'(8'h30 + r));
            cmd(16'h00C4, 16'h0005);
            cmd(16'h00C1, 16'(8'h60 + r));
        end
        cmd(16'h00C3, 16'h0018);
        cmd(16'h00C6, 16'h0000);
        check_eq("scroll_busy_cycles", last_busy, 1960);
        check_eq("scroll_ready_low", last_rdy, 0);
        check_cursor("scroll_cur", 0, 24);
        nz = 0;
        for (int k = 0; k < 24; k++) begin
            for (int c = 0; c < 40; c++) begin
                read_cell(k * 40 + c, d);
                if (c == 0) check_eq("scroll_col0", d, 12'h300 + 12'(8'h31 + k));
                else if (c == 5) check_eq("scroll_col5", d, 12'h300 + 12'(8'h61 + k));
                else if (d != 12'h000) nz++;
            end
        end
        check_eq("scroll_rows_other", nz, 0);
        nz = 0;
        for (int c = 0; c < 40; c++) begin
            read_cell(960 + c, d);
            if (d != 12'h000) nz++;
        end
        check_eq("scroll_last_row_blank", nz, 0);

        // Saturating cursor set, NOP, unknown opcode
        cmd(16'h00C4, 16'h00FF);
        cmd(16'h00C3, 16'h00FF);
        check_cursor("sat_cur", 39, 24);
        cmd(16'h00C8, 16'h0000);
        send(16'h0000);
        cmd(16'h00C1, 16'h0041);
        check_cell("nop_put_cell999", 999, 12'h341);
        check_cursor("nop_put_cur", 0, 0);
        cmd(16'h0055, 16'h1234);
        check_cursor("unk_cur", 0, 0);
        check_eq("unk_busy", last_busy, 0);
        cmd(16'h00C1, 16'h0042);
        check_cell("unk_attr_cell0", 0, 12'h342);
        check_cursor("unk_put_cur", 1, 0);

        // Soft reset opcode
        cmd(16'h00C7, 16'h0005);
        cmd(16'h00C8, 16'h0001);
        cmd(16'h00C4, 16'h0005);
        cmd(16'h00C0, 16'h0000);
        check_cursor("soft_rst_cur", 0, 0);
        cmd(16'h00C1, 16'h0044);
        check_cell("soft_rst_attr", 0, 12'hF44);
        cmd(16'h00C3, 16'h0018);
        cmd(16'h00C6, 16'h0000);
        check_eq("soft_rst_mode_busy", last_busy, 0);
        check_cursor("soft_rst_mode_cur", 0, 0);

        // clr during a scroll
        cmd(16'h00C8, 16'h0001);
        cmd(16'h00C4, 16'h0014);
        cmd(16'h00C1, 16'h0041);
        cmd(16'h00C3, 16'h0018);
        cmd(16'h00C4, 16'h0000);
        cmd(16'h00C1, 16'h0042);
        check_cursor("pre_abort_cur", 1, 24);
        send(16'h00C6);
        send(16'h0000);
        @(negedge clk);
        repeat (20) @(negedge clk);
        check_eq("abort_busy_before", busy, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", cmd_ready, 1);
        check_cursor("abort_cur", 0, 0);
        check_eq("abort_rd_data", rd_data, 0);
        repeat (5) @(negedge clk);
        check_cell("abort_cell0_scrolled", 0, 12'h332);
        check_cell("abort_cell5_scrolled", 5, 12'h362);
        check_cell("abort_cell20_kept", 20, 12'hF41);
        check_cell("abort_cell960_kept", 960, 12'hF42);
        cmd(16'h00C3, 16'h0018);
        cmd(16'h00C6, 16'h0000);
        check_eq("abort_mode_busy", last_busy, 0);
        check_cursor("abort_mode_cur", 0, 0);
        cmd(16'h00C1, 16'h0043);
        check_cell("abort_attr_cell0", 0, 12'hF43);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
